// File: rtl/mapping_ptr_fetch.sv
// mapping_ptr_fetch: reads PTR_COUNT mapping pointers from BRAM, decodes each
// into {way,row} and queues it in a FIFO. The FIFO head is issued to the AXI
// command issuer in strict order, gated by the per-way NFC busy flags.
// Optional build macro: PTR_VALID_CHK_EN (drop pointers whose valid bit is 0).
module mapping_ptr_fetch #(
    parameter logic [31:0] START_ADDR = 32'h4580_0000,
    parameter int unsigned PTR_COUNT  = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        ram_clk,
    output logic        ram_rst,
    output logic [31:0] ram_addr,
    output logic        ram_en,
    input  logic [31:0] ram_rd_data,
    input  logic [7:0]  check_nfc_busy,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [2:0]  cmd_way,
    output logic [23:0] cmd_row,
    output logic        busy,
    output logic        done,
    output logic [7:0]  fetch_cnt
);

    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [7:0]  PTR_CNT8 = 8'(PTR_COUNT);

    typedef enum logic [2:0] {IDLE, RD, CAP, DRAIN, FIN} state_t;

    state_t          state, next_state;
    logic            cap_pending;
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [AW:0]     count, count_next;
    logic [26:0]     mem [FIFO_DEPTH];
    logic [26:0]     head;
    logic            push, pop, ptr_ok;
    logic [7:0]      fetch_cnt_next;
    logic            unused_rsvd;

    assign ram_clk = clk;
    assign ram_rst = ~rst_n;

    assign unused_rsvd = ^ram_rd_data[31:27];

`ifdef PTR_VALID_CHK_EN
    assign ptr_ok = ram_rd_data[31];
`else
    assign ptr_ok = 1'b1;
`endif

    assign head       = mem[rd_ptr];
    assign pop        = cmd_valid & cmd_ready;
    assign push       = (state == CAP) & cap_pending & ptr_ok;
    assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);

    // Next-state and run-counter decode; CAP only advances to RD when the
    // FIFO will have room for the next captured pointer.
    always_comb begin
        next_state     = state;
        fetch_cnt_next = fetch_cnt;
        case (state)
            IDLE: begin
                if (start && (count != DEPTH_C)) begin
                    next_state     = RD;
                    fetch_cnt_next = '0;
                end
            end
            RD: next_state = CAP;
            CAP: begin
                if (cap_pending) fetch_cnt_next = fetch_cnt + 8'd1;
                if (fetch_cnt_next < PTR_CNT8) begin
                    if (count_next != DEPTH_C) next_state = RD;
                end else begin
                    next_state = DRAIN;
                end
            end
            DRAIN: if ((count == '0) && !cmd_valid) next_state = FIN;
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FIFO storage for decoded {way,row}; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= ram_rd_data[26:0];
    end

    // Fetch FSM, FIFO pointers and registered command/BRAM outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cap_pending <= 1'b0;
            fetch_cnt   <= '0;
            ram_addr    <= '0;
            ram_en      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            cmd_valid   <= 1'b0;
            cmd_way     <= '0;
            cmd_row     <= '0;
        end else begin
            state       <= next_state;
            fetch_cnt   <= fetch_cnt_next;
            busy        <= (next_state != IDLE);
            done        <= (next_state == FIN);
            ram_en      <= (next_state == RD);
            cap_pending <= (state == RD);
            if (next_state == RD)
                ram_addr <= START_ADDR + {22'd0, fetch_cnt_next, 2'b00};

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;

            // The command is latched from the head once its way is idle and
            // then held until accepted, so later busy changes cannot retract it.
            if (pop) begin
                cmd_valid <= 1'b0;
            end else if (!cmd_valid && (count != '0) && !check_nfc_busy[head[26:24]]) begin
                cmd_valid <= 1'b1;
                cmd_way   <= head[26:24];
                cmd_row   <= head[23:0];
            end
        end
    end

endmodule

// File: tb/tb_mapping_ptr_fetch.sv
// Self-checking bench for mapping_ptr_fetch (PTR_COUNT=8, FIFO_DEPTH=4).
module tb_mapping_ptr_fetch;

    localparam logic [31:0] START = 32'h4580_0000;
    localparam int          NPTR  = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        ram_clk, ram_rst;
    logic [31:0] ram_addr;
    logic        ram_en;
    logic [31:0] ram_rd_data = '0;
    logic [7:0]  check_nfc_busy;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_way;
    logic [23:0] cmd_row;
    logic        busy, done;
    logic [7:0]  fetch_cnt;

    mapping_ptr_fetch #(.START_ADDR(START), .PTR_COUNT(NPTR), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ram_clk(ram_clk), .ram_rst(ram_rst), .ram_addr(ram_addr), .ram_en(ram_en),
        .ram_rd_data(ram_rd_data), .check_nfc_busy(check_nfc_busy),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_way(cmd_way), .cmd_row(cmd_row),
        .busy(busy), .done(done), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic [2:0]  way;
        logic [23:0] row;
        bit          vld;
    } vec_t;

    typedef struct packed {
        logic [2:0]  way;
        logic [23:0] row;
    } cmd_t;

    vec_t        tbl [NPTR];
    logic [31:0] bram [NPTR];
    cmd_t        sb [$];

    int passed = 0;
    int total  = 0;
    int reads, acc, dones, n_exp;
    bit mon_on;
    bit prev_hold;
    logic [2:0]  prev_way;
    logic [23:0] prev_row;

    // BRAM model with one-cycle read latency
    always @(posedge clk) begin
        if (ram_en) begin
            if (((ram_addr - START) >> 2) < NPTR)
                ram_rd_data <= bram[(ram_addr - START) >> 2];
            else
                ram_rd_data <= 32'hDEAD_BEEF;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    endtask

    task automatic monitor();
        cmd_t e;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (prev_hold) begin
                    chk("hold_valid", {31'd0, cmd_valid}, 32'd1);
                    chk("hold_way", {29'd0, cmd_way}, {29'd0, prev_way});
                    chk("hold_row", {8'd0, cmd_row}, {8'd0, prev_row});
                end
                if (ram_en) begin
                    chk("ram_addr", ram_addr, START + 32'(reads) * 32'd4);
                    reads++;
                end
                if (cmd_valid && cmd_ready) begin
                    if (sb.size() == 0) begin
                        chk("cmd_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("cmd_way", {29'd0, cmd_way}, {29'd0, e.way});
                        chk("cmd_row", {8'd0, cmd_row}, {8'd0, e.row});
                    end
                    acc++;
                end
                if (done) dones++;
                prev_hold = cmd_valid && !cmd_ready;
                prev_way  = cmd_way;
                prev_row  = cmd_row;
            end else begin
                prev_hold = 1'b0;
            end
        end
    endtask

    task automatic load_sb();
        sb.delete();
        for (int i = 0; i < NPTR; i++) begin
`ifdef PTR_VALID_CHK_EN
            if (!tbl[i].vld) continue;
`endif
            sb.push_back({tbl[i].way, tbl[i].row});
        end
        n_exp = sb.size();
    endtask

    task automatic start_run();
        @(posedge clk); #1;
        start = 1'b1;
        reads = 0; acc = 0; dones = 0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("run_completes", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_run_end(input string tag);
        chk({tag, "_done_pulses"}, 32'(dones), 32'd1);
        chk({tag, "_reads"}, 32'(reads), 32'(NPTR));
        chk({tag, "_fetch_cnt"}, {24'd0, fetch_cnt}, 32'(NPTR));
        chk({tag, "_cmds"}, 32'(acc), 32'(n_exp));
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ram_addr"}, ram_addr, 32'd0);
        chk({tag, "_ram_en"}, {31'd0, ram_en}, 32'd0);
        chk({tag, "_cmd_valid"}, {31'd0, cmd_valid}, 32'd0);
        chk({tag, "_cmd_way"}, {29'd0, cmd_way}, 32'd0);
        chk({tag, "_cmd_row"}, {8'd0, cmd_row}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_fetch_cnt"}, {24'd0, fetch_cnt}, 32'd0);
        chk({tag, "_ram_rst"}, {31'd0, ram_rst}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cmd_ready = 1'b1; check_nfc_busy = '0;
        mon_on = 1'b0; prev_hold = 1'b0; reads = 0; acc = 0; dones = 0; n_exp = 0;

        tbl[0] = '{32'h8100_0010, 3'd1, 24'h000010, 1'b1};
        tbl[1] = '{32'h8200_0020, 3'd2, 24'h000020, 1'b1};
        tbl[2] = '{32'h8300_0030, 3'd3, 24'h000030, 1'b1};
        tbl[3] = '{32'h8400_0040, 3'd4, 24'h000040, 1'b1};
        tbl[4] = '{32'hF500_0050, 3'd5, 24'h000050, 1'b1};
        tbl[5] = '{32'h86AB_CDEF, 3'd6, 24'hABCDEF, 1'b1};
        tbl[6] = '{32'h0700_0070, 3'd7, 24'h000070, 1'b0};
        tbl[7] = '{32'h80FF_FFFF, 3'd0, 24'hFFFFFF, 1'b1};
        for (int i = 0; i < NPTR; i++) bram[i] = tbl[i].word;

        // Reset state
        #2;
        check_all_zero("reset");
        chk("ram_clk", {31'd0, ram_clk}, {31'd0, clk});
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        fork monitor(); join_none
        mon_on = 1'b1;

        // Basic run, with a stray start mid-run that must be ignored
        load_sb();
        start_run();
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_idle(400);
        check_run_end("basic");
        repeat (3) @(negedge clk);
        chk("fetch_cnt_held", {24'd0, fetch_cnt}, 32'(NPTR));
        chk("done_low_idle", {31'd0, done}, 32'd0);

        // Busy head way blocks issue; once raised, valid holds despite busy
        load_sb();
        check_nfc_busy = 8'h02;
        start_run();
        repeat (20) @(negedge clk);
        chk("blocked_valid", {31'd0, cmd_valid}, 32'd0);
        chk("blocked_reads", 32'(reads), 32'd4);
        @(posedge clk); #1;
        cmd_ready = 1'b0;
        check_nfc_busy = 8'h00;
        @(negedge clk);
        chk("unblock_same_cycle", {31'd0, cmd_valid}, 32'd0);
        @(negedge clk);
        chk("unblock_next_cycle", {31'd0, cmd_valid}, 32'd1);
        chk("unblock_way", {29'd0, cmd_way}, 32'd1);
        @(posedge clk); #1;
        check_nfc_busy = 8'h02;
        repeat (3) @(negedge clk);
        chk("rebusy_valid", {31'd0, cmd_valid}, 32'd1);
        chk("rebusy_row", {8'd0, cmd_row}, 32'h10);
        @(posedge clk); #1 cmd_ready = 1'b1;
        wait_idle(400);
        check_run_end("busyway");
        check_nfc_busy = 8'h00;

        // FIFO full stall: no consumer, reads must stop at FIFO depth
        load_sb();
        cmd_ready = 1'b0;
        start_run();
        repeat (30) @(negedge clk);
        chk("stall_reads", 32'(reads), 32'd4);
        chk("stall_ram_en", {31'd0, ram_en}, 32'd0);
        chk("stall_fetch_cnt", {24'd0, fetch_cnt}, 32'd4);
        chk("stall_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1 cmd_ready = 1'b1;
        wait_idle(400);
        check_run_end("stall");

        // Reset asserted in CAP with two entries queued
        load_sb();
        cmd_ready = 1'b0;
        start_run();
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (reads == 3) break;
        end
        chk("midrst_reached_cap", 32'(reads), 32'd3);
        #1;
        mon_on = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cmd_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("postrst_busy", {31'd0, busy}, 32'd0);
        chk("postrst_valid", {31'd0, cmd_valid}, 32'd0);
        chk("postrst_ram_en", {31'd0, ram_en}, 32'd0);
        mon_on = 1'b1;

        // Fresh run after reset restarts at entry 0
        load_sb();
        start_run();
        wait_idle(400);
        check_run_end("afterrst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
